// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide, one bit per cycle, then a sign-fix cycle.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mdop,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    input  logic             we_hi,
    input  logic             we_lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [1:0]         op_q, op_d;
    logic               sa_q, sa_d, sb_q, sb_d, bz_q, bz_d;
    logic [WIDTH-1:0]   a_orig_q, a_orig_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;

    logic               start_signed;
    logic [WIDTH:0]     rem_sh, trial;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic n);
        return n ? -x : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] x, input logic n);
        return n ? -x : x;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        bz_d     = bz_q;
        a_orig_d = a_orig_q;
        acc_d    = acc_q;
        opa_d    = opa_q;
        opb_d    = opb_q;

        start_signed = ~mdop[0];
        // Partial remainder shifted left with the next dividend bit brought down.
        rem_sh = {acc_q[WIDTH-1:0], opa_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, opb_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d     = mdop;
                    a_orig_d = DataA;
                    sa_d     = start_signed & DataA[WIDTH-1];
                    sb_d     = start_signed & DataB[WIDTH-1];
                    bz_d     = mdop[1] & (DataB == '0);
                    opa_d    = {{WIDTH{1'b0}}, cond_neg(DataA, start_signed & DataA[WIDTH-1])};
                    opb_d    = cond_neg(DataB, start_signed & DataB[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end else begin
                    if (we_hi) hi_d = DataA;
                    if (we_lo) lo_d = DataA;
                end
            end
            CALC: begin
                if (!op_q[1]) begin
                    if (opb_q[0]) acc_d = acc_q + opa_q;
                    opb_d = opb_q >> 1;
                end else begin
                    // Quotient bits collect in the upper half, remainder in the lower half.
                    acc_d[2*WIDTH-1:WIDTH] = {acc_q[2*WIDTH-2:WIDTH], ~trial[WIDTH]};
                    acc_d[WIDTH-1:0]       = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
                end
                opa_d = opa_q << 1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FIX: begin
                if (!op_q[1]) begin
                    {hi_d, lo_d} = cond_neg_wide(acc_q, sa_q ^ sb_q);
                end else if (bz_q) begin
                    lo_d  = '1;
                    hi_d  = a_orig_q;
                    dbz_d = 1'b1;
                end else begin
                    lo_d = cond_neg(acc_q[2*WIDTH-1:WIDTH], sa_q ^ sb_q);
                    hi_d = cond_neg(acc_q[WIDTH-1:0], sa_q);
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            bz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            bz_q    <= bz_d;
        end
    end

    // Datapath registers are only meaningful once an operation is launched.
    always_ff @(posedge clk) begin
        a_orig_q <= a_orig_d;
        acc_q    <= acc_d;
        opa_q    <= opa_d;
        opb_q    <= opb_d;
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
